// File: rtl/hid_report_pkg.sv
// Shared types and constants for the HID boot-mouse report builder.
// Imported by the accumulator and the report FSM.
package hid_report_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND0 = 3'd1,
    SEND1 = 3'd2,
    SEND2 = 3'd3,
    SEND3 = 3'd4
  } state_t;

  localparam int BTN        = 0;
  localparam int X          = 1;
  localparam int Y          = 2;
  localparam int W          = 3;
  localparam int REPORT_LEN = 4;
  localparam int CLAMP_DEF  = 127;

  function automatic logic [1:0] byte_idx(input state_t s);
    return 2'(s - SEND0);
  endfunction

endpackage

// File: rtl/hid_report_builder_sat_accum.sv
// Signed saturating accumulator: acc <= sat(acc - sub + pt + inj).
// sat pulses in any cycle whose sum leaves the W-bit signed range.
module sat_accum #(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] sub,
  input  logic signed [W-1:0] pt,
  input  logic signed [W-1:0] inj,
  output logic signed [W-1:0] acc,
  output logic                sat
);

  localparam int SW = W + 2;
  localparam logic signed [SW-1:0] MAXV =
    SW'((64'd1 << (W - 1)) - 64'd1);
  localparam logic signed [SW-1:0] MINV =
    -SW'(64'd1 << (W - 1));

  // Two guard bits hold the worst-case sum of four terms.
  logic signed [SW-1:0] sum;
  logic hi;
  logic lo;

  always_comb begin
    sum = {{2{acc[W-1]}}, acc}
        - {{2{sub[W-1]}}, sub}
        + {{2{pt[W-1]}}, pt}
        + {{2{inj[W-1]}}, inj};
    hi  = sum > MAXV;
    lo  = sum < MINV;
    sat = hi || lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (hi) begin
      acc <= MAXV[W-1:0];
    end else if (lo) begin
      acc <= MINV[W-1:0];
    end else begin
      acc <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/hid_report_builder.sv
// Merges passthrough and injected mouse motion into 4-byte
// boot-protocol IN reports, or NAKs when nothing changed.
module hid_report_builder
  import hid_report_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CLAMP = CLAMP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pt_valid,
  input  logic [7:0]       pt_buttons,
  input  logic [7:0]       pt_dx,
  input  logic [7:0]       pt_dy,
  input  logic [7:0]       pt_wheel,
  input  logic             inj_valid,
  output logic             inj_ready,
  input  logic [ACC_W-1:0] inj_dx,
  input  logic [ACC_W-1:0] inj_dy,
  input  logic [7:0]       inj_wheel,
  input  logic [7:0]       inj_buttons,
  input  logic             in_req,
  output logic             in_nak,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_last,
  input  logic             tx_ready,
  output logic             sat_flag
);

  localparam logic signed [ACC_W-1:0] LIM = ACC_W'(CLAMP);

  function automatic logic [7:0] clamp8(
    input logic signed [ACC_W-1:0] a
  );
    if (a > LIM) return 8'(CLAMP);
    else if (a < -LIM) return 8'(-CLAMP);
    else return a[7:0];
  endfunction

  function automatic logic [ACC_W-1:0] sx8(input logic [7:0] v);
    return {{(ACC_W-8){v[7]}}, v};
  endfunction

  state_t state;
  state_t nxt;

  logic signed [ACC_W-1:0] acc_x;
  logic signed [ACC_W-1:0] acc_y;
  logic signed [ACC_W-1:0] acc_w;
  logic signed [ACC_W-1:0] sub_x, sub_y, sub_w;
  logic signed [ACC_W-1:0] pt_x, pt_y, pt_w;
  logic signed [ACC_W-1:0] in_x, in_y, in_w;
  logic sat_x, sat_y, sat_w;

  logic [7:0] pt_btn_q;
  logic [7:0] inj_btn_q;
  logic [7:0] last_btn;
  logic [7:0] btn;
  logic [7:0] nx, ny, nw;
  logic [REPORT_LEN-1:0][7:0] rep_q;
  logic inj_acc;
  logic empty;
  logic commit;
  logic poll;

  always_comb begin
    inj_acc = inj_valid && inj_ready;
    btn     = pt_btn_q | inj_btn_q;
    nx      = clamp8(acc_x);
    ny      = clamp8(acc_y);
    nw      = clamp8(acc_w);
    empty   = (nx == 8'd0) && (ny == 8'd0) &&
              (nw == 8'd0) && (btn == last_btn);
    poll    = (state == IDLE) && in_req;
    commit  = (state == SEND3) && tx_ready;
    sub_x   = commit ? sx8(rep_q[X]) : '0;
    sub_y   = commit ? sx8(rep_q[Y]) : '0;
    sub_w   = commit ? sx8(rep_q[W]) : '0;
    pt_x    = pt_valid ? sx8(pt_dx) : '0;
    pt_y    = pt_valid ? sx8(pt_dy) : '0;
    pt_w    = pt_valid ? sx8(pt_wheel) : '0;
    in_x    = inj_acc ? inj_dx : '0;
    in_y    = inj_acc ? inj_dy : '0;
    in_w    = inj_acc ? sx8(inj_wheel) : '0;
  end

  sat_accum #(.W(ACC_W)) u_acc_x (
    .clk(clk), .rst(rst),
    .sub(sub_x), .pt(pt_x), .inj(in_x),
    .acc(acc_x), .sat(sat_x)
  );

  sat_accum #(.W(ACC_W)) u_acc_y (
    .clk(clk), .rst(rst),
    .sub(sub_y), .pt(pt_y), .inj(in_y),
    .acc(acc_y), .sat(sat_y)
  );

  sat_accum #(.W(ACC_W)) u_acc_w (
    .clk(clk), .rst(rst),
    .sub(sub_w), .pt(pt_w), .inj(in_w),
    .acc(acc_w), .sat(sat_w)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (in_req && !empty) nxt = SEND0;
      SEND0:   if (tx_ready) nxt = SEND1;
      SEND1:   if (tx_ready) nxt = SEND2;
      SEND2:   if (tx_ready) nxt = SEND3;
      SEND3:   if (tx_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = state != IDLE;
    tx_last  = state == SEND3;
    tx_data  = tx_valid ? rep_q[byte_idx(state)] : 8'd0;
  end

  // Snapshot only in IDLE so tx_data is stable through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q     <= '0;
      in_nak    <= 1'b0;
      inj_ready <= 1'b0;
      sat_flag  <= 1'b0;
      pt_btn_q  <= 8'd0;
      inj_btn_q <= 8'd0;
      last_btn  <= 8'd0;
    end else begin
      inj_ready <= 1'b1;
      in_nak    <= poll && empty;
      if (sat_x || sat_y || sat_w) sat_flag <= 1'b1;
      if (pt_valid) pt_btn_q <= pt_buttons;
      if (inj_acc) inj_btn_q <= inj_buttons;
      if (commit) last_btn <= rep_q[BTN];
      if (poll && !empty) begin
        rep_q[BTN] <= btn;
        rep_q[X]   <= nx;
        rep_q[Y]   <= ny;
        rep_q[W]   <= nw;
      end
    end
  end

endmodule

// File: doc/hid_report_builder.md
Name: hid_report_builder

Overview:
- Builds 4-byte boot-protocol mouse IN reports for the HID interrupt endpoint of usb_hid_injector.
- Sits directly upstream of that core and merges two sources:
  - passthrough mouse reports from the real device;
  - injection commands from the control path.
- Keeps signed movement accumulators.
- On each IN poll, either streams a report byte-wise to the USB core or signals NAK when there is nothing new to send.

Parameters:
ACC_W, 16, width of signed X/Y/wheel accumulators (two's complement, saturating)
CLAMP, 127, magnitude limit for the per-report movement bytes (report range -CLAMP..+CLAMP)

Ports:
clk  in  1  system clock (usb_clk domain)
rst  in  1  synchronous, active-high reset
pt_valid  in  1  passthrough report strobe, one cycle, always accepted
pt_buttons  in  8  passthrough button bitmap
pt_dx  in  8  passthrough signed X delta
pt_dy  in  8  passthrough signed Y delta
pt_wheel  in  8  passthrough signed wheel delta
inj_valid  in  1  injection command valid
inj_ready  out  1  injection command ready
inj_dx  in  ACC_W  injected signed X delta
inj_dy  in  ACC_W  injected signed Y delta
inj_wheel  in  8  injected signed wheel delta
inj_buttons  in  8  injected button bitmap, held until the next injection command
in_req  in  1  one-cycle pulse: IN token received for the HID endpoint
in_nak  out  1  one-cycle pulse: nothing new to report
tx_data  out  8  report byte
tx_valid  out  1  report byte valid
tx_last  out  1  marks byte 3
tx_ready  in  1  USB core accepts the byte
sat_flag  out  1  sticky: an accumulator saturated since reset

Behaviour:
- Reset values (rst synchronous, dominates every other input, including mid-report):
  - inj_ready=0, in_nak=0, tx_valid=0, tx_last=0, tx_data=0, sat_flag=0.
  - Accumulators, held injected buttons and last-sent buttons all cleared.
  - FSM returns to IDLE; a partially sent report is abandoned.
- inj_ready is 1 in every cycle after reset; an injection is accepted on inj_valid & inj_ready.
- Accumulators acc_x, acc_y, acc_w are ACC_W signed. Per-cycle update:
  - acc_next = sat(acc - sent + pt_term + inj_term).
  - pt_term is the sign-extended passthrough delta when pt_valid, else 0.
  - inj_term is the injected delta when the injection is accepted, else 0 (inj_wheel is sign-extended).
  - sent is nonzero only in the commit cycle.
  - All three terms apply in the same cycle without loss.
  - sat() clamps to the ACC_W signed range and sets sat_flag.
- Buttons: btn = pt_buttons_held | inj_buttons_held. pt_buttons_held updates on pt_valid; inj_buttons_held updates on an accepted injection.
- FSM states: IDLE, SEND0, SEND1, SEND2, SEND3.
- IDLE, in_req=1:
  - Snapshot rep_x = clamp(acc_x, ±CLAMP); same for rep_y and rep_w. Snapshot rep_b = btn.
  - If all three deltas are 0 and rep_b == last_sent_buttons: pulse in_nak in cycle N+1 and stay in IDLE.
  - Otherwise go to SEND0; tx_valid=1 with tx_data=rep_b in cycle N+1.
- SENDk: present byte k. Byte order: 0 buttons, 1 X, 2 Y, 3 wheel. Advance on tx_ready only; tx_data must stay stable while tx_valid & !tx_ready.
- SEND3: tx_last=1. On tx_ready this is the commit cycle:
  - Subtract rep_x, rep_y and rep_w from the accumulators (the residual is kept).
  - last_sent_buttons <= rep_b.
  - Return to IDLE; tx_valid=0 in the next cycle.
- in_req while in SEND0..SEND3 is ignored: no NAK, no re-snapshot.
- Accumulation continues during SEND. New motion lands in the residual and is reported on the next poll.
- Back-to-back: in_req in the cycle directly after commit is served normally.

Decomposition:
- Package hid_report_pkg holds:
  - FSM state encoding;
  - report byte offsets (BTN=0, X=1, Y=2, W=3) and REPORT_LEN=4;
  - the CLAMP default.
- One sub-module, sat_accum: a parameterised-width signed accumulator with three signed addend inputs (subtract, passthrough, inject) and a saturation output. It is instantiated three times (X, Y, wheel).

Test Plan:
1. Reset, then in_req with no input -> in_nak pulses at N+1, tx_valid stays 0, inj_ready=1 from the first post-reset cycle.
2. Inject dx=+300, dy=-5, buttons=0x01, then in_req with tx_ready=1 -> bytes 0x01, 0x7F, 0xFB, 0x00 with tx_last on byte 3. Next in_req -> 0x01, 0x7F, 0x00, 0x00. Next -> 0x01, 0x2E, 0x00, 0x00. Next -> in_nak.
3. Passthrough dx=+10 and injection dx=+20 in the same cycle, plus a second passthrough dx=-3 during SEND1 of an earlier report -> that report is unaffected, next report X = 0x1B (27).
4. Stall tx_ready low for 5 cycles at SEND2 -> tx_data holds the Y byte; an in_req during the stall is ignored, with no in_nak.
5. Inject dx=+32767 twice with ACC_W=16 -> acc_x saturates at 32767 and sat_flag=1, remaining set until rst.
6. Assert rst during SEND1 -> next cycle tx_valid=0 and accumulators 0; following in_req -> in_nak.
